wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources.
- Source A is the single-cycle ALU path: highest priority, never back-pressured.
- Source B is the long-latency path (load/mul-div): valid/ready handshake, buffered in a DEPTH-entry FIFO.
- Drives we/address/data of the register file, starvation-guards B, and exposes a pending-write lookup for hazard logic in decode.

Parameters:
- WIDTH, 32, data width of a register write.
- INDEX, 5, register address width.
- DEPTH, 4, B-side FIFO entries (power of two, >=2).
- MAX_WAIT, 8, cycles the FIFO head may be denied before forcing a stall of source A (>=1).

Ports:
- clk_in  input  1  clock, all state on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- a_valid_in  input  1  ALU result valid this cycle.
- a_rd_in  input  INDEX  ALU destination register.
- a_data_in  input  WIDTH  ALU result.
- b_valid_in  input  1  long-latency result valid.
- b_ready_out  output  1  B accepted when b_valid_in & b_ready_out.
- b_rd_in  input  INDEX  B destination register.
- b_data_in  input  WIDTH  B result.
- stall_out  output  1  registered; source A producer must hold a_valid_in=0 while high.
- query_rs_in  input  INDEX  register to check for a pending B write.
- query_busy_out  output  1  combinational; 1 if any valid FIFO entry has rd==query_rs_in and rd!=0.
- we_out  output  1  register file write enable (registered).
- waddr_out  output  INDEX  register file write address (registered).
- wdata_out  output  WIDTH  register file write data (registered).
- conflict_out  output  1  sticky error: a_valid_in seen while stall_out=1.

Behaviour:
- Reset (async, immediate):
  - we_out=0, waddr_out=0, wdata_out=0, stall_out=0, conflict_out=0.
  - FIFO empty, wait counter 0, state IDLE.
  - b_ready_out=1 once reset is deasserted.
- b_ready_out = !full, computed from the registered count only. No push when full, even in a cycle that pops.
- Slot selection each cycle; the winner is registered onto we/waddr/wdata at the next edge:
  - (1) state STARVED: pop FIFO head.
  - (2) else if a_valid_in: write A.
  - (3) else if FIFO non-empty: pop head.
  - (4) else if bypass enabled and B handshake: write B directly; it is not enqueued.
  - (5) else we_out=0 next cycle. waddr_out/wdata_out hold their last values.
- Latency:
  - A: 1 cycle (accept at N, we_out at N+1).
  - B via FIFO: minimum 2 cycles (push at N, head eligible at N+1, we_out at N+2).
- Writes to rd=0 are accepted and consume the slot, but we_out stays 0.
- FIFO order is strict FIFO. Simultaneous push and pop are allowed when not full; count is unchanged.
- Wait counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at MAX_WAIT.
- State machine:
  - IDLE -> STARVED when the counter reaches MAX_WAIT. stall_out=1 while in STARVED.
  - STARVED lasts exactly one cycle: head popped, then -> IDLE with counter 0.
  - If the FIFO is still non-empty, the counter restarts from 0.
- A stall hazard: if a_valid_in=1 while stall_out=1, the A write is dropped, the head still wins, and conflict_out is set until reset.
- Reset mid-operation discards all FIFO contents and clears any in-progress stall.
- WAW ordering between A and B to the same rd is the issue stage's responsibility; decode uses query_busy_out to enforce it.

Optional Feature:
- WB_ARB_BYPASS_EN defined: rule (4) active. B accepted into an empty FIFO while A is idle and state is IDLE reaches we_out in 1 cycle and is never enqueued.
- Not defined: every B result passes through the FIFO (minimum 2-cycle latency).
- In both builds, query_busy_out covers FIFO entries only.

Test Plan:
- Reset: after rst_in pulse, we_out=0, b_ready_out=1, stall_out=0, conflict_out=0. Asserting rst_in with 3 entries queued empties the FIFO immediately.
- A only: a_valid_in=1, rd=5, data=0x1234 at cycle N -> we_out=1, waddr_out=5, wdata_out=0x1234 at N+1.
- B through FIFO, bypass off: b push rd=7, data=0xCAFE at N with A idle -> write seen at N+2. While queued, query_rs_in=7 -> query_busy_out=1.
- Full, then starvation:
  - Push 4 B entries while A busy every cycle -> b_ready_out=0 after the 4th push.
  - After MAX_WAIT=8 denied cycles -> stall_out=1 for exactly 1 cycle, and the head is written in that slot.
  - Holding a_valid_in=1 during stall_out -> conflict_out=1.
- x0 and ordering: B pushes rd=0, rd=3, rd=4 -> no write for rd 0; writes to 3 then 4 in order. Simultaneous push and pop at count=2 -> count stays 2.
- Bypass build: WB_ARB_BYPASS_EN defined, FIFO empty, A idle, B rd=9 at N -> we_out at N+1, and query_busy_out for 9 is never 1.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU source A has priority over a FIFO-buffered long-latency source B.
// Optional macro WB_ARB_BYPASS_EN lets B write directly when the FIFO is empty, A is idle and no stall is active.
module wb_arbiter #(
  parameter int WIDTH    = 32,
  parameter int INDEX    = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             a_valid_in,
  input  logic [INDEX-1:0] a_rd_in,
  input  logic [WIDTH-1:0] a_data_in,
  input  logic             b_valid_in,
  output logic             b_ready_out,
  input  logic [INDEX-1:0] b_rd_in,
  input  logic [WIDTH-1:0] b_data_in,
  output logic             stall_out,
  input  logic [INDEX-1:0] query_rs_in,
  output logic             query_busy_out,
  output logic             we_out,
  output logic [INDEX-1:0] waddr_out,
  output logic [WIDTH-1:0] wdata_out,
  output logic             conflict_out
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, STARVED} state_t;

  state_t           state, state_next;
  logic [INDEX-1:0] rd_mem   [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic             empty, push, pop, bypass;
  logic             vld_p0;
  logic [INDEX-1:0] rd_p0;
  logic [WIDTH-1:0] data_p0;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v >= WAIT_W'(MAX_WAIT)) ? v : v + 1'b1;
  endfunction

  assign empty       = (count == '0);
  assign b_ready_out = (count != CNT_W'(DEPTH));
  assign stall_out   = (state == STARVED);

  // Stage p0: pick this cycle's winner for the write port
  always_comb begin
    vld_p0  = 1'b0;
    rd_p0   = rd_mem[rd_ptr];
    data_p0 = data_mem[rd_ptr];
    pop     = 1'b0;
    bypass  = 1'b0;
    if (state == STARVED) begin
      vld_p0 = 1'b1;
      pop    = 1'b1;
    end else if (a_valid_in) begin
      vld_p0  = 1'b1;
      rd_p0   = a_rd_in;
      data_p0 = a_data_in;
    end else if (!empty) begin
      vld_p0 = 1'b1;
      pop    = 1'b1;
    end
`ifdef WB_ARB_BYPASS_EN
    else if (b_valid_in && b_ready_out) begin
      vld_p0  = 1'b1;
      bypass  = 1'b1;
      rd_p0   = b_rd_in;
      data_p0 = b_data_in;
    end
`endif
    push       = b_valid_in && b_ready_out && !bypass;
    wait_next  = (pop || empty) ? '0 : sat_inc(wait_cnt);
    state_next = (state == IDLE && wait_next == WAIT_W'(MAX_WAIT)) ? STARVED : IDLE;
  end

  always_comb begin
    query_busy_out = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count && rd_mem[rd_ptr + PTR_W'(i)] == query_rs_in && query_rs_in != '0)
        query_busy_out = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      rd_mem[wr_ptr]   <= b_rd_in;
      data_mem[wr_ptr] <= b_data_in;
    end
  end

  // Stage p1: registered write port and arbiter control state
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      wait_cnt     <= '0;
      conflict_out <= 1'b0;
      we_out       <= 1'b0;
      waddr_out    <= '0;
      wdata_out    <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      count    <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (stall_out && a_valid_in) conflict_out <= 1'b1;
      we_out <= vld_p0 && (rd_p0 != '0);
      if (vld_p0) begin
        waddr_out <= rd_p0;
        wdata_out <= data_p0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        a_valid_in, b_valid_in, b_ready_out, stall_out, query_busy_out, we_out, conflict_out;
  logic [4:0]  a_rd_in, b_rd_in, query_rs_in, waddr_out;
  logic [31:0] a_data_in, b_data_in, wdata_out;

  wb_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .a_valid_in(a_valid_in), .a_rd_in(a_rd_in), .a_data_in(a_data_in),
    .b_valid_in(b_valid_in), .b_ready_out(b_ready_out), .b_rd_in(b_rd_in), .b_data_in(b_data_in),
    .stall_out(stall_out), .query_rs_in(query_rs_in), .query_busy_out(query_busy_out),
    .we_out(we_out), .waddr_out(waddr_out), .wdata_out(wdata_out), .conflict_out(conflict_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      m_q[$];
  int          m_wait;
  bit          m_starved, m_conflict, m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          compared = 0;
  int          mismatched = 0;
  logic        last_busy;
  logic [4:0]  wr_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wait = 0; m_starved = 0; m_conflict = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
  endtask

  function automatic bit model_busy(input logic [4:0] q);
    bit r = 0;
    foreach (m_q[i]) if (m_q[i].rd == q && q != 0) r = 1;
    return r;
  endfunction

  task automatic model_step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                            input logic bv, input logic [4:0] brd, input logic [31:0] bd);
    entry_t w;
    bit win, byp, popped, hs;
    int pre;
    win = 0; byp = 0; popped = 0;
    pre = m_q.size();
    hs  = bv && (pre < DEPTH);
    if (m_starved) begin
      w = m_q.pop_front(); win = 1; popped = 1;
      if (av) m_conflict = 1;
    end else if (av) begin
      w.rd = ard; w.data = ad; win = 1;
    end else if (pre > 0) begin
      w = m_q.pop_front(); win = 1; popped = 1;
    end else if (BYPASS && hs) begin
      w.rd = brd; w.data = bd; win = 1; byp = 1;
    end
    if (hs && !byp) begin
      entry_t e;
      e.rd = brd; e.data = bd;
      m_q.push_back(e);
    end
    if (popped || pre == 0) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    m_starved = !m_starved && (m_wait == MAX_WAIT);
    if (win) begin
      m_we = (w.rd != 0); m_waddr = w.rd; m_wdata = w.data;
    end else m_we = 0;
  endtask

  // Entered one time unit after a rising edge; leaves one time unit after the next one.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic [4:0] q);
    a_valid_in = av; a_rd_in = ard; a_data_in = ad;
    b_valid_in = bv; b_rd_in = brd; b_data_in = bd;
    query_rs_in = q;
    #1;
    last_busy = query_busy_out;
    chk("b_ready", b_ready_out, (m_q.size() < DEPTH));
    chk("query_busy", query_busy_out, model_busy(q));
    model_step(av, ard, ad, bv, brd, bd);
    @(posedge clk_in); #1;
    chk("we", we_out, m_we);
    chk("waddr", waddr_out, m_waddr);
    chk("wdata", wdata_out, m_wdata);
    chk("stall", stall_out, m_starved);
    chk("conflict", conflict_out, m_conflict);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_in = 1'b1;
    a_valid_in = 0; a_rd_in = 0; a_data_in = 0;
    b_valid_in = 0; b_rd_in = 0; b_data_in = 0; query_rs_in = 0;
    model_reset();
    @(posedge clk_in); @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    chk("rst_we", we_out, 0);
    chk("rst_ready", b_ready_out, 1);
    chk("rst_stall", stall_out, 0);
    chk("rst_conflict", conflict_out, 0);

    // A only: one-cycle latency
    cycle(1, 5, 32'h1234, 0, 0, 0, 0);
    chk("a_we", we_out, 1);
    chk("a_waddr", waddr_out, 5);
    chk("a_wdata", wdata_out, 32'h1234);
    idle(1);

    // B through the FIFO (explicit latency checks in the non-bypass build)
    cycle(0, 0, 0, 1, 7, 32'hCAFE, 7);
    if (!BYPASS) begin
      chk("b_we_n1", we_out, 0);
      cycle(0, 0, 0, 0, 0, 0, 7);
      chk("b_busy7", last_busy, 1);
      chk("b_we_n2", we_out, 1);
      chk("b_waddr", waddr_out, 7);
      chk("b_wdata", wdata_out, 32'hCAFE);
    end
    idle(DEPTH + 2);

    // Fill with A busy every cycle, then starvation and stall hazard
    for (int i = 0; i < 12; i++) begin
      cycle(1, 5'($urandom_range(1, 31)), $urandom, (i < 4), 5'(10 + i), 32'hB000 + i, 0);
      if (i == 3) chk("full_ready", b_ready_out, 0);
      if (i == 8) chk("starve_stall", stall_out, 1);
      if (i == 9) begin
        chk("starve_end", stall_out, 0);
        chk("starve_we", we_out, 1);
        chk("starve_waddr", waddr_out, 10);
        chk("starve_wdata", wdata_out, 32'hB000);
        chk("conflict_set", conflict_out, 1);
      end
    end

    // Reset with three entries queued
    a_valid_in = 0; b_valid_in = 0; query_rs_in = 12;
    #1;
    chk("pre_rst_busy", query_busy_out, 1);
    rst_in = 1'b1;
    #1;
    chk("midrst_busy", query_busy_out, 0);
    chk("midrst_we", we_out, 0);
    chk("midrst_stall", stall_out, 0);
    chk("midrst_conflict", conflict_out, 0);
    chk("midrst_ready", b_ready_out, 1);
    model_reset();
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;

    // x0 writes are swallowed; order preserved
    wr_q.delete();
    cycle(0, 0, 0, 1, 0, 32'h100, 0); if (we_out) wr_q.push_back(waddr_out);
    cycle(0, 0, 0, 1, 3, 32'h103, 3); if (we_out) wr_q.push_back(waddr_out);
    cycle(0, 0, 0, 1, 4, 32'h104, 4); if (we_out) wr_q.push_back(waddr_out);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 0); if (we_out) wr_q.push_back(waddr_out);
    end
    chk("order_n", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      chk("order_0", wr_q[0], 3);
      chk("order_1", wr_q[1], 4);
    end

    // Simultaneous push and pop at count 2 leaves count at 2
    cycle(1, 1, 32'h1, 1, 20, 32'h200, 0);
    cycle(1, 2, 32'h2, 1, 21, 32'h201, 0);
    cycle(0, 0, 0, 1, 22, 32'h202, 21);
    cycle(1, 3, 32'h3, 1, 23, 32'h203, 0);
    chk("pp_ready_3", b_ready_out, 1);
    cycle(1, 4, 32'h4, 1, 24, 32'h204, 0);
    chk("pp_ready_full", b_ready_out, 0);
    idle(DEPTH + 2);

    if (BYPASS) begin
      cycle(0, 0, 0, 1, 9, 32'h999, 9);
      chk("byp_busy_n", last_busy, 0);
      chk("byp_we", we_out, 1);
      chk("byp_waddr", waddr_out, 9);
      chk("byp_wdata", wdata_out, 32'h999);
      cycle(0, 0, 0, 0, 0, 0, 9);
      chk("byp_busy_n1", last_busy, 0);
    end

    // Random traffic, light then heavy A load; A obeys the stall
    for (int k = 0; k < 800; k++) begin
      int pa;
      pa = (k < 400) ? 5 : 9;
      cycle((!m_starved) && ($urandom_range(0, 9) < pa), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
